// File: rtl/packed_entry_mem_if.sv
// ============================================================================
// packed_entry_mem_if
//   Write/clear/read bus bundle for the chunk-packing entry memory.
//   Revision: 1.0
// ============================================================================
`default_nettype none

interface packed_entry_mem_if #(
  parameter int DEPTH   = 128,
  parameter int ENTRY_W = 128,
  parameter int IN_W    = 8,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CNT_W   = $clog2(ENTRY_W / IN_W + 1)
);
  logic               wen;
  logic [ADDR_W-1:0]  wr_addr;
  logic [IN_W-1:0]    in_data;
  logic               wr_ack;
  logic               wr_err;
  logic               clr;
  logic [ADDR_W-1:0]  clr_addr;
  logic               ren;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic [CNT_W-1:0]   rd_count;
  logic               rd_valid;
  logic               rd_full;
  logic [ADDR_W:0]    num_full;

  modport master (
    output wen, wr_addr, in_data, clr, clr_addr, ren, rd_addr,
    input  wr_ack, wr_err, rd_data, rd_count, rd_valid, rd_full, num_full
  );

  modport slave (
    input  wen, wr_addr, in_data, clr, clr_addr, ren, rd_addr,
    output wr_ack, wr_err, rd_data, rd_count, rd_valid, rd_full, num_full
  );
endinterface

`default_nettype wire

// File: rtl/packed_entry_mem.sv
// ============================================================================
// packed_entry_mem
//   Shifts narrow chunks into wide per-entry storage with per-entry fill
//   counts, masked reads, same-cycle bypass and a running full-entry count.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module packed_entry_mem #(
  parameter int DEPTH   = 128,
  parameter int ENTRY_W = 128,
  parameter int IN_W    = 8,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  packed_entry_mem_if.slave  bus
);

  localparam int CHUNKS = ENTRY_W / IN_W;
  localparam int CNT_W  = $clog2(CHUNKS + 1);

  localparam logic [CNT_W-1:0]  c_chunks = CNT_W'(CHUNKS);
  localparam logic [CNT_W-1:0]  c_one    = CNT_W'(1);
  localparam logic [ADDR_W:0]   c_depth  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_nf_one = (ADDR_W + 1)'(1);

  logic [ENTRY_W-1:0] r_data [DEPTH];
  logic [CNT_W-1:0]   r_cnt  [DEPTH];
  logic [ADDR_W:0]    r_num_full;
  logic               r_wr_ack;
  logic               r_wr_err;
  logic               r_rd_valid;
  logic [ENTRY_W-1:0] r_rd_data;
  logic [CNT_W-1:0]   r_rd_count;
  logic               r_rd_full;

  logic               w_wr_in;
  logic               w_clr_in;
  logic               w_rd_in;
  logic               w_clr_hit;
  logic [CNT_W-1:0]   w_wr_base;
  logic [CNT_W-1:0]   w_wr_cnt;
  logic               w_wr_acc;
  logic               w_wr_rej;
  logic [ENTRY_W-1:0] w_wr_data;
  logic               w_inc;
  logic               w_dec;
  logic [CNT_W-1:0]   w_rd_cnt;
  logic [ENTRY_W-1:0] w_rd_raw;
  logic [ENTRY_W-1:0] w_rd_mask;
  logic [ENTRY_W-1:0] w_rd_val;

  assign w_wr_in  = ({1'b0, bus.wr_addr}  < c_depth);
  assign w_clr_in = ({1'b0, bus.clr_addr} < c_depth);
  assign w_rd_in  = ({1'b0, bus.rd_addr}  < c_depth);

  // A same-address clear is applied before the write, so the write sees count 0.
  always_comb begin
    w_clr_hit = bus.clr && w_clr_in;
    w_wr_base = (w_clr_hit && (bus.clr_addr == bus.wr_addr)) ? '0 : r_cnt[bus.wr_addr];
    w_wr_acc  = bus.wen && w_wr_in && (w_wr_base != c_chunks);
    w_wr_rej  = bus.wen && !w_wr_acc;
    w_wr_cnt  = w_wr_base + c_one;
    w_wr_data = {r_data[bus.wr_addr][ENTRY_W-IN_W-1:0], bus.in_data};
    w_inc     = w_wr_acc && (w_wr_cnt == c_chunks);
    w_dec     = w_clr_hit && (r_cnt[bus.clr_addr] == c_chunks);
  end

  // Read path sees the post-update entry when it collides with a write or clear.
  always_comb begin
    w_rd_raw = r_data[bus.rd_addr];
    w_rd_cnt = r_cnt[bus.rd_addr];
    if (w_wr_acc && (bus.wr_addr == bus.rd_addr)) begin
      w_rd_raw = w_wr_data;
      w_rd_cnt = w_wr_cnt;
    end else if (w_clr_hit && (bus.clr_addr == bus.rd_addr)) begin
      w_rd_cnt = '0;
    end
    if (!w_rd_in) begin
      w_rd_cnt = '0;
    end
    w_rd_mask = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (CNT_W'(i) < w_rd_cnt) begin
        w_rd_mask[i*IN_W +: IN_W] = '1;
      end
    end
    w_rd_val = w_rd_raw & w_rd_mask;
  end

  // Payload storage carries no reset; stale contents are hidden by the mask.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_data[bus.wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_num_full <= '0;
    end else begin
      if (w_clr_hit) begin
        r_cnt[bus.clr_addr] <= '0;
      end
      if (w_wr_acc) begin
        r_cnt[bus.wr_addr] <= w_wr_cnt;
      end
      case ({w_inc, w_dec})
        2'b10:   r_num_full <= r_num_full + c_nf_one;
        2'b01:   r_num_full <= r_num_full - c_nf_one;
        default: r_num_full <= r_num_full;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ack   <= 1'b0;
      r_wr_err   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_count <= '0;
      r_rd_full  <= 1'b0;
    end else begin
      r_wr_ack   <= w_wr_acc;
      r_wr_err   <= w_wr_rej;
      r_rd_valid <= bus.ren;
      if (bus.ren) begin
        r_rd_data  <= w_rd_val;
        r_rd_count <= w_rd_cnt;
        r_rd_full  <= (w_rd_cnt == c_chunks);
      end
    end
  end

  assign bus.wr_ack   = r_wr_ack;
  assign bus.wr_err   = r_wr_err;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_count = r_rd_count;
  assign bus.rd_full  = r_rd_full;
  assign bus.num_full = r_num_full;

endmodule

`default_nettype wire

// File: tb/tb_packed_entry_mem.sv
// ============================================================================
// tb_packed_entry_mem
//   Directed scoreboard bench for packed_entry_mem (DEPTH=4, 32-bit entries,
//   8-bit chunks). Revision: 1.0
// ============================================================================
`default_nettype none

module tb_packed_entry_mem;

  localparam int WR_NONE = 0;
  localparam int WR_ACK  = 1;
  localparam int WR_ERR  = 2;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  count;
    logic        full;
    logic [2:0]  nfull;
  } rd_exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  int      wq[$];
  rd_exp_t rq[$];

  packed_entry_mem_if #(.DEPTH(4), .ENTRY_W(32), .IN_W(8)) bus ();

  packed_entry_mem #(.DEPTH(4), .ENTRY_W(32), .IN_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_ack || bus.wr_err) begin
        if (wq.size() == 0) begin
          chk("unexpected_wr_resp", {30'd0, bus.wr_err, bus.wr_ack}, 32'd0);
        end else begin
          int e;
          e = wq.pop_front();
          chk("wr_resp", {30'd0, bus.wr_err, bus.wr_ack}, (e == WR_ACK) ? 32'd1 : 32'd2);
        end
      end
      if (bus.rd_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          rd_exp_t r;
          r = rq.pop_front();
          chk("rd_data",  bus.rd_data, r.data);
          chk("rd_count", {29'd0, bus.rd_count}, {29'd0, r.count});
          chk("rd_full",  {31'd0, bus.rd_full}, {31'd0, r.full});
          chk("num_full", {29'd0, bus.num_full}, {29'd0, r.nfull});
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic c, input logic [1:0] ca,
                       input logic re, input logic [1:0] ra);
    bus.wen = we; bus.wr_addr = wa; bus.in_data = wd;
    bus.clr = c;  bus.clr_addr = ca;
    bus.ren = re; bus.rd_addr = ra;
  endtask

  task automatic op(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                    input logic c, input logic [1:0] ca,
                    input logic re, input logic [1:0] ra,
                    input int ew, input logic [31:0] ed, input logic [2:0] ec,
                    input logic [2:0] enf);
    rd_exp_t r;
    @(posedge clk);
    #1;
    drive(we, wa, wd, c, ca, re, ra);
    if (ew != WR_NONE) wq.push_back(ew);
    if (re) begin
      r.data = ed; r.count = ec; r.full = (ec == 3'd4); r.nfull = enf;
      rq.push_back(r);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ed, input logic [2:0] ec,
                    input logic [2:0] enf);
    op(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, a, WR_NONE, ed, ec, enf);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input int ew);
    op(1'b1, a, d, 1'b0, 2'd0, 1'b0, 2'd0, ew, 32'd0, 3'd0, 3'd0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr_ack"},   {31'd0, bus.wr_ack},   32'd0);
    chk({tag, "_wr_err"},   {31'd0, bus.wr_err},   32'd0);
    chk({tag, "_rd_valid"}, {31'd0, bus.rd_valid}, 32'd0);
    chk({tag, "_rd_data"},  bus.rd_data,           32'd0);
    chk({tag, "_rd_count"}, {29'd0, bus.rd_count}, 32'd0);
    chk({tag, "_rd_full"},  {31'd0, bus.rd_full},  32'd0);
    chk({tag, "_num_full"}, {29'd0, bus.num_full}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Empty memory reads back zero everywhere.
    for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, 3'd0, 3'd0);

    // Three chunks into entry 2.
    wr(2'd2, 8'h11, WR_ACK);
    wr(2'd2, 8'h22, WR_ACK);
    wr(2'd2, 8'h33, WR_ACK);
    rd(2'd2, 32'h0011_2233, 3'd3, 3'd0);
    idle();
    @(posedge clk);
    @(negedge clk);
    chk("hold_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("hold_rd_data",  bus.rd_data, 32'h0011_2233);

    // Fourth chunk fills entry 2 (bypassed read), fifth is rejected.
    op(1'b1, 2'd2, 8'h44, 1'b0, 2'd0, 1'b1, 2'd2, WR_ACK, 32'h1122_3344, 3'd4, 3'd1);
    op(1'b1, 2'd2, 8'h55, 1'b0, 2'd0, 1'b1, 2'd2, WR_ERR, 32'h1122_3344, 3'd4, 3'd1);

    // Clear + write + read of the same entry in one cycle.
    op(1'b1, 2'd2, 8'hAA, 1'b1, 2'd2, 1'b1, 2'd2, WR_ACK, 32'h0000_00AA, 3'd1, 3'd0);

    // Empty entry 2 again, then fill all four entries back-to-back.
    op(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, WR_NONE, 32'h0, 3'd0, 3'd0);
    for (int a = 0; a < 4; a++)
      for (int j = 1; j <= 4; j++)
        wr(2'(a), 8'(a * 16 + j), WR_ACK);
    rd(2'd0, 32'h0102_0304, 3'd4, 3'd4);
    rd(2'd1, 32'h1112_1314, 3'd4, 3'd4);
    rd(2'd2, 32'h2122_2324, 3'd4, 3'd4);
    rd(2'd3, 32'h3132_3334, 3'd4, 3'd4);
    op(1'b1, 2'd0, 8'h99, 1'b0, 2'd0, 1'b1, 2'd0, WR_ERR, 32'h0102_0304, 3'd4, 3'd4);

    // Clear entry 1 (bypassed read), refill it while entry 0 is cleared.
    op(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 2'd1, WR_NONE, 32'h0, 3'd0, 3'd3);
    wr(2'd1, 8'hA1, WR_ACK);
    wr(2'd1, 8'hA2, WR_ACK);
    wr(2'd1, 8'hA3, WR_ACK);
    op(1'b1, 2'd1, 8'hA4, 1'b1, 2'd0, 1'b1, 2'd1, WR_ACK, 32'hA1A2_A3A4, 3'd4, 3'd3);
    rd(2'd0, 32'h0, 3'd0, 3'd3);
    rd(2'd3, 32'h3132_3334, 3'd4, 3'd3);

    // Drain, then reset lands between a write and its acknowledge.
    idle();
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 drive(1'b1, 2'd0, 8'h77, 1'b0, 2'd0, 1'b1, 2'd1);
    #2 reset = 1'b1;
    #1 drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0);
    wq.delete();
    rq.delete();
    @(negedge clk);
    chk_zero_outputs("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    rd(2'd1, 32'h0, 3'd0, 3'd0);
    rd(2'd0, 32'h0, 3'd0, 3'd0);
    idle();
    repeat (4) @(posedge clk);
    @(negedge clk);

    chk("wr_queue_drained", wq.size(), 32'd0);
    chk("rd_queue_drained", rq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
